// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of mem_arbiter.
// master is the arbiter's view; slave is the requesters plus the memory.
interface mem_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 4,
  parameter int ADDR_WIDTH = 6
) ();
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_wr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]      req_wdata;
  logic [NUM_REQ-1:0]            req_ack;
  logic [NUM_REQ-1:0]            req_err;
  logic [WIDTH-1:0]              req_rdata;
  logic [GW-1:0]                 grant_id;
  logic                          busy;
  logic                          mem_valid;
  logic                          mem_wr_rd_en;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [WIDTH-1:0]              mem_wdata;
  logic [WIDTH-1:0]              mem_rdata;
  logic                          mem_ready;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_ack, req_err, req_rdata, grant_id, busy,
           mem_valid, mem_wr_rd_en, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_ack, req_err, req_rdata, grant_id, busy,
           mem_valid, mem_wr_rd_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters.
// Defining MEM_ARB_TIMEOUT_EN adds a WAIT timeout that completes the transaction with an error pulse.
module mem_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DEPTH          = 64,
  parameter int WIDTH          = 4,
  parameter int ADDR_WIDTH     = $clog2(DEPTH),
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic           clk_i,
  input logic           rst_i,
  mem_arbiter_if.master bus
);
  // state | meaning
  // IDLE  | sample requests, pick round-robin winner, latch its command
  // ISSUE | present latched command to memory for one cycle
  // WAIT  | wait for memory ready (or timeout when enabled)
  // RESP  | one-cycle ack (and err) pulse to the winner
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [GW-1:0]         ptr;
  logic [GW-1:0]         grant_q;
  logic [GW-1:0]         winner;
  logic [GW-1:0]         cand;
  logic                  win_found;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [WIDTH-1:0]      cmd_wdata;
  logic [NUM_REQ-1:0]    ack_q;
  logic [WIDTH-1:0]      rdata_q;
  logic                  tmo_hit;
  logic                  resp_go;
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [WIDTH-1:0]      wdata_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k]  = bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[k] = bus.req_wdata[k*WIDTH +: WIDTH];
  end

  // Search starts just after the last winner and wraps, so a held request cannot starve others.
  always_comb begin
    winner    = ptr;
    win_found = 1'b0;
    cand      = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (cand == GW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!win_found && bus.req_valid[cand]) begin
        winner    = cand;
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (resp_go) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_valid = (state == ISSUE);
    bus.busy      = (state != IDLE);
  end

  assign resp_go          = (state == WAIT) && (bus.mem_ready || tmo_hit);
  assign bus.mem_wr_rd_en = cmd_wr;
  assign bus.mem_addr     = cmd_addr;
  assign bus.mem_wdata    = cmd_wdata;
  assign bus.req_ack      = ack_q;
  assign bus.req_rdata    = rdata_q;
  assign bus.grant_id     = grant_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr       <= GW'(NUM_REQ - 1);
      grant_q   <= '0;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
    end else begin
      ack_q <= '0;
      if (state == IDLE && win_found) begin
        ptr       <= winner;
        grant_q   <= winner;
        cmd_wr    <= bus.req_wr[winner];
        cmd_addr  <= addr_arr[winner];
        cmd_wdata <= wdata_arr[winner];
      end
      // A timeout completion returns zero data, as does any write.
      if (resp_go) begin
        ack_q[grant_q] <= 1'b1;
        rdata_q        <= (bus.mem_ready && !cmd_wr) ? bus.mem_rdata : '0;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0]      tmo_cnt;
  logic [NUM_REQ-1:0] err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                tmo_cnt <= '0;
    else if (state == ISSUE)                   tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
    else if (state == WAIT && tmo_cnt != '0)   tmo_cnt <= tmo_cnt - 1'b1;
  end

  // Ready arriving in the terminal cycle still wins over the timeout.
  assign tmo_hit = (state == WAIT) && !bus.mem_ready && (tmo_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= '0;
    end else begin
      err_q <= '0;
      if (tmo_hit) err_q[grant_q] <= 1'b1;
    end
  end

  assign bus.req_err = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign bus.req_err = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized traffic
// checked against a cycle-level reference of the arbitration and memory contents.
module tb_mem_arbiter;
  localparam int NR = 4;
  localparam int AW = 6;
  localparam int DW = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NUM_REQ(NR), .WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(
    .NUM_REQ(NR), .DEPTH(64), .WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_b),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // memory device: registered read, ready the cycle after a sampled valid
  logic [DW-1:0] dev_mem [64];
  logic [DW-1:0] ref_mem [64];
  logic          dev_ready  = 1'b0;
  logic [DW-1:0] dev_rdata  = '0;
  logic          stall      = 1'b0;
  logic          junk_en    = 1'b0;
  logic          junk_ready = 1'b0;
  logic [DW-1:0] junk_rdata = '0;

  always @(posedge clk) begin
    dev_ready <= bus.mem_valid;
    if (bus.mem_valid) begin
      if (bus.mem_wr_rd_en) dev_mem[bus.mem_addr] <= bus.mem_wdata;
      else                  dev_rdata <= dev_mem[bus.mem_addr];
    end
  end

  assign bus.mem_ready = junk_en ? junk_ready : (dev_ready && !stall);
  assign bus.mem_rdata = junk_en ? junk_rdata : dev_rdata;

  logic [NR-1:0] pv;
  logic [NR-1:0] pw;
  logic [AW-1:0] pa [NR];
  logic [DW-1:0] pd [NR];

  task automatic drive();
    bus.req_valid = pv;
    bus.req_wr    = pw;
    for (int k = 0; k < NR; k++) begin
      bus.req_addr[k*AW +: AW]  = pa[k];
      bus.req_wdata[k*DW +: DW] = pd[k];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] p, input int last);
    for (int i = 1; i <= NR; i++)
      if (p[(last + i) % NR]) return (last + i) % NR;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"},   bus.req_ack, 0);
    chk({tag, "_err"},   bus.req_err, 0);
    chk({tag, "_rdata"}, bus.req_rdata, 0);
    chk({tag, "_grant"}, bus.grant_id, 0);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_mvld"},  bus.mem_valid, 0);
    chk({tag, "_mwr"},   bus.mem_wr_rd_en, 0);
    chk({tag, "_maddr"}, bus.mem_addr, 0);
    chk({tag, "_mwd"},   bus.mem_wdata, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_b = 1'b0;
    pv = '0;
    drive();
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  // One request from requester k issued in an IDLE cycle (cycle 0); ack expected at exp_cyc.
  task automatic do_single(input int k, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                           input int exp_cyc, input logic exp_err, input string tag);
    int            cyc;
    int            ack_cyc;
    int            vcount;
    int            vcyc;
    logic [NR-1:0] ack_seen;
    logic [NR-1:0] err_seen;
    logic [DW-1:0] rd_seen;
    logic          c_wr;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wd;
    @(negedge clk);
    pv = '0; pv[k] = 1'b1; pw[k] = wr; pa[k] = a; pd[k] = d;
    drive();
    cyc = 0; ack_cyc = -1; vcount = 0; vcyc = -1;
    ack_seen = '0; err_seen = '0; rd_seen = '0;
    c_wr = 1'b0; c_addr = '0; c_wd = '0;
    while (ack_cyc < 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_valid) begin
        vcount++; vcyc = cyc;
        c_wr = bus.mem_wr_rd_en; c_addr = bus.mem_addr; c_wd = bus.mem_wdata;
      end
      if (bus.req_ack != '0) begin
        ack_cyc = cyc; ack_seen = bus.req_ack; err_seen = bus.req_err; rd_seen = bus.req_rdata;
      end
    end
    pv[k] = 1'b0;
    drive();
    chk({tag, "_ack_cycle"}, ack_cyc, exp_cyc);
    chk({tag, "_ack"},       ack_seen, 32'(1) << k);
    chk({tag, "_err"},       err_seen, exp_err ? (32'(1) << k) : 0);
    chk({tag, "_rdata"},     rd_seen, exp_rd);
    chk({tag, "_mvld_cnt"},  vcount, 1);
    chk({tag, "_mvld_cyc"},  vcyc, 1);
    chk({tag, "_mwr"},       c_wr, wr);
    chk({tag, "_maddr"},     c_addr, a);
    chk({tag, "_mwd"},       c_wd, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_idx [NR];
    int ack_cyc [NR];
    logic [DW-1:0] ack_rd [NR];
    int nacks;
    int vcnt;
    int grants [$];
    logic regain;
    int n, next_idle, issue_c, ack_c, win, last, grant_exp, just;
    logic e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rd;

    for (int i = 0; i < 64; i++) begin
      dev_mem[i] = DW'(i * 7 + 3);
      ref_mem[i] = DW'(i * 7 + 3);
    end
    for (int k = 0; k < NR; k++) begin pa[k] = '0; pd[k] = '0; end
    pv = '0; pw = '0;
    rst_b = 1'b0;
    drive();

    // 1: reset held with random inputs, then idle with no requests
    junk_en = 1'b1;
    repeat (6) begin
      @(negedge clk);
      pv = NR'($urandom); pw = NR'($urandom);
      for (int k = 0; k < NR; k++) begin pa[k] = AW'($urandom); pd[k] = DW'($urandom); end
      drive();
      junk_ready = 1'($urandom); junk_rdata = DW'($urandom);
      #1 check_all_zero("t1_rst");
    end
    @(negedge clk);
    pv = '0; drive(); junk_en = 1'b0;
    rst_b = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t1_idle_busy", bus.busy, 0);
      chk("t1_idle_mvld", bus.mem_valid, 0);
      chk("t1_idle_ack",  bus.req_ack, 0);
    end

    // 2: requester 1 writes 0xA to addr 5, then reads it back
    do_single(1, 1'b1, AW'(5), DW'(4'hA), DW'(0), 3, 1'b0, "t2_wr");
    ref_mem[5] = DW'(4'hA);
    do_single(1, 1'b0, AW'(5), DW'(0), DW'(4'hA), 3, 1'b0, "t2_rd");

    // 3: all requesters read at once and hold until acked
    pulse_reset();
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin pv[k] = 1'b1; pw[k] = 1'b0; pa[k] = AW'(8 + k); pd[k] = '0; end
    drive();
    nacks = 0; vcnt = 0;
    for (int c = 1; c <= 30 && nacks < NR; c++) begin
      @(negedge clk);
      if (bus.mem_valid) vcnt++;
      if (bus.req_ack != '0) begin
        ack_idx[nacks] = onehot_idx(bus.req_ack);
        ack_cyc[nacks] = c;
        ack_rd[nacks]  = bus.req_rdata;
        if (ack_idx[nacks] >= 0) pv[ack_idx[nacks]] = 1'b0;
        drive();
        nacks++;
      end
    end
    chk("t3_nacks", nacks, NR);
    chk("t3_mvld_cnt", vcnt, NR);
    for (int j = 0; j < nacks; j++) begin
      chk("t3_order", ack_idx[j], j);
      chk("t3_ack_cycle", ack_cyc[j], 3 + 4 * j);
      chk("t3_rdata", ack_rd[j], ref_mem[8 + j]);
    end

    // 4: requester 2 held, requester 0 pulsed; grants must alternate
    @(negedge clk);
    pv = '0; pv[0] = 1'b1; pv[2] = 1'b1; pw = '0; pa[0] = AW'(20); pa[2] = AW'(21);
    drive();
    regain = 1'b0;
    grants.delete();
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      if (regain) begin pv[0] = 1'b1; regain = 1'b0; end
      if (bus.req_ack != '0) begin
        grants.push_back(onehot_idx(bus.req_ack));
        if (bus.req_ack[0]) begin pv[0] = 1'b0; regain = 1'b1; end
      end
      drive();
    end
    pv = '0; drive();
    chk("t4_ngrants", grants.size(), 6);
    for (int j = 0; j < grants.size() && j < 6; j++)
      chk("t4_alternate", grants[j], (j % 2 == 0) ? 0 : 2);

    // 5: reset asserted while a read is stalled in WAIT
    @(negedge clk);
    stall = 1'b1;
    pv = '0; pv[1] = 1'b1; pw[1] = 1'b0; pa[1] = AW'(5);
    drive();
    repeat (4) @(negedge clk);
    chk("t5_busy_before", bus.busy, 1);
    chk("t5_grant_before", bus.grant_id, 1);
    chk("t5_ack_before", bus.req_ack, 0);
    #2 rst_b = 1'b0;
    #1 check_all_zero("t5_rst");
    pv = '0; drive();
    stall = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_ack", bus.req_ack, 0);
      chk("t5_idle_busy", bus.busy, 0);
    end
    do_single(3, 1'b0, AW'(5), DW'(0), ref_mem[5], 3, 1'b0, "t5_after");

`ifdef MEM_ARB_TIMEOUT_EN
    // 6: memory never answers; timeout completes with ack+err and zero data
    stall = 1'b1;
    do_single(0, 1'b0, AW'(9), DW'(0), DW'(0), 2 + TO, 1'b1, "t6_tmo");
    stall = 1'b0;
`endif

    // randomized traffic against the reference model
    pulse_reset();
    last = NR - 1; grant_exp = 0; next_idle = 0; issue_c = -1; ack_c = -1; win = 0;
    e_wr = 1'b0; e_addr = '0; e_wdata = '0; e_rd = '0;
    for (n = 0; n < 800; n++) begin
      @(negedge clk);
      chk("rnd_busy",  bus.busy, 32'(n < next_idle));
      chk("rnd_mvld",  bus.mem_valid, 32'(n == issue_c));
      if (n == issue_c) begin
        chk("rnd_mwr",   bus.mem_wr_rd_en, e_wr);
        chk("rnd_maddr", bus.mem_addr, e_addr);
        chk("rnd_mwd",   bus.mem_wdata, e_wdata);
      end
      chk("rnd_ack",   bus.req_ack, (n == ack_c) ? (32'(1) << win) : 0);
      chk("rnd_err",   bus.req_err, 0);
      chk("rnd_grant", bus.grant_id, grant_exp);
      if (n == ack_c) chk("rnd_rdata", bus.req_rdata, e_rd);
      just = -1;
      if (n == ack_c) begin pv[win] = 1'b0; just = win; end
      for (int k = 0; k < NR; k++) begin
        if (!pv[k] && k != just && $urandom_range(0, 3) == 0) begin
          pv[k] = 1'b1;
          pw[k] = 1'($urandom_range(0, 1));
          pa[k] = AW'($urandom_range(0, 15));
          pd[k] = DW'($urandom_range(0, 15));
        end
      end
      drive();
      if (n == next_idle) begin
        if (pv != '0) begin
          win = rr_pick(pv, last);
          last = win; grant_exp = win;
          issue_c = n + 1; ack_c = n + 3; next_idle = n + 4;
          e_wr = pw[win]; e_addr = pa[win]; e_wdata = pd[win];
          if (e_wr) begin ref_mem[e_addr] = e_wdata; e_rd = '0; end
          else e_rd = ref_mem[e_addr];
        end else begin
          next_idle = n + 1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
